// File: rtl/ecc_secded_pipe.sv
// Two-stage SEC-DED decoder: stage 1 registers syndrome and overall parity,
// stage 2 classifies, optionally corrects, and counts the errors it reports.
module ecc_secded_pipe #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned CNT_W  = 16,
   // smallest r with 2^r >= DATA_W + r + 1
   localparam int unsigned HAM_W  = (DATA_W <= 1)   ? 2 :
                                    (DATA_W <= 4)   ? 3 :
                                    (DATA_W <= 11)  ? 4 :
                                    (DATA_W <= 26)  ? 5 :
                                    (DATA_W <= 57)  ? 6 :
                                    (DATA_W <= 120) ? 7 : 8,
   localparam int unsigned CHK_W  = HAM_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CHK_W-1:0]  in_chk,
   input  logic              corr_en,
   input  logic              cnt_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              err_sec,
   output logic              err_ded,
   output logic [HAM_W-1:0]  err_pos,
   output logic [CNT_W-1:0]  cnt_sec,
   output logic [CNT_W-1:0]  cnt_ded
);

   localparam int unsigned CW_N = DATA_W + HAM_W;

   // Codeword position of data bit idx: the idx-th non-power-of-two position.
   function automatic logic [HAM_W-1:0] data_pos(input int unsigned idx);
      int unsigned      seen;
      logic [HAM_W-1:0] pos;
      seen = 0;
      pos  = '0;
      for (int unsigned p = 3; p <= CW_N; p++) begin
         if ((p & (p - 32'd1)) != 32'd0) begin
            if (seen == idx) pos = HAM_W'(p);
            seen++;
         end
      end
      return pos;
   endfunction

   logic              s1_load, s2_load;
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic              s1_corr_q, s1_corr_d;
   logic [HAM_W-1:0]  s1_syn_q, s1_syn_d;
   logic              s1_par_q, s1_par_d;
   logic [HAM_W-1:0]  syn_c, enc_pos;
   logic              par_c;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              err_sec_q, err_sec_d;
   logic              err_ded_q, err_ded_d;
   logic [HAM_W-1:0]  err_pos_q, err_pos_d;
   logic              sec_c, ded_c;
   logic [HAM_W-1:0]  pos_c, dec_pos;
   logic [DATA_W-1:0] fix_data_c;

   logic [CNT_W-1:0]  cnt_sec_q, cnt_sec_d;
   logic [CNT_W-1:0]  cnt_ded_q, cnt_ded_d;

   // A stage loads when empty or when its word leaves in the same cycle.
   assign s2_load  = ~out_valid_q | out_ready;
   assign s1_load  = ~s1_valid_q | s2_load;
   assign in_ready = rst_n & s1_load;

   // Syndrome = recomputed Hamming bits XOR received ones; parity over the whole word.
   always_comb begin
      syn_c   = in_chk[HAM_W-1:0];
      enc_pos = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         enc_pos = data_pos(i);
         for (int unsigned k = 0; k < HAM_W; k++) begin
            if (enc_pos[k]) syn_c[k] = syn_c[k] ^ in_data[i];
         end
      end
      par_c = ^{in_data, in_chk};
   end

   // Stage-1 next state.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_corr_d  = s1_corr_q;
      s1_syn_d   = s1_syn_q;
      s1_par_d   = s1_par_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_corr_d = corr_en;
            s1_syn_d  = syn_c;
            s1_par_d  = par_c;
         end
      end
   end

   // Stage-1 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_corr_q  <= 1'b0;
         s1_syn_q   <= '0;
         s1_par_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_corr_q  <= s1_corr_d;
         s1_syn_q   <= s1_syn_d;
         s1_par_q   <= s1_par_d;
      end
   end

   // Classify the stage-1 word; an odd-weight syndrome outside the codeword is uncorrectable.
   always_comb begin
      sec_c      = 1'b0;
      ded_c      = 1'b0;
      pos_c      = '0;
      fix_data_c = s1_data_q;
      dec_pos    = '0;
      if (s1_par_q) begin
         if (32'(s1_syn_q) <= CW_N) begin
            sec_c = 1'b1;
            pos_c = s1_syn_q;
            if (s1_corr_q) begin
               for (int unsigned i = 0; i < DATA_W; i++) begin
                  dec_pos = data_pos(i);
                  if (dec_pos == s1_syn_q) fix_data_c[i] = ~s1_data_q[i];
               end
            end
         end else begin
            ded_c = 1'b1;
         end
      end else if (s1_syn_q != '0) begin
         ded_c = 1'b1;
      end
   end

   // Stage-2 next state; flags are forced low whenever the stage empties.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_sec_d   = err_sec_q;
      err_ded_d   = err_ded_q;
      err_pos_d   = err_pos_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         err_sec_d   = s1_valid_q & sec_c;
         err_ded_d   = s1_valid_q & ded_c;
         err_pos_d   = s1_valid_q ? pos_c : '0;
         if (s1_valid_q) out_data_d = fix_data_c;
      end
   end

   // Stage-2 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_sec_q   <= 1'b0;
         err_ded_q   <= 1'b0;
         err_pos_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_sec_q   <= err_sec_d;
         err_ded_q   <= err_ded_d;
         err_pos_q   <= err_pos_d;
      end
   end

   // Saturating error counters; clear wins over a same-cycle increment.
   always_comb begin
      cnt_sec_d = cnt_sec_q;
      cnt_ded_d = cnt_ded_q;
      if (cnt_clr) begin
         cnt_sec_d = '0;
         cnt_ded_d = '0;
      end else if (out_valid_q && out_ready) begin
         if (err_sec_q && (cnt_sec_q != '1)) cnt_sec_d = cnt_sec_q + CNT_W'(1);
         if (err_ded_q && (cnt_ded_q != '1)) cnt_ded_d = cnt_ded_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_sec_q <= '0;
         cnt_ded_q <= '0;
      end else begin
         cnt_sec_q <= cnt_sec_d;
         cnt_ded_q <= cnt_ded_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err_sec   = err_sec_q;
   assign err_ded   = err_ded_q;
   assign err_pos   = err_pos_q;
   assign cnt_sec   = cnt_sec_q;
   assign cnt_ded   = cnt_ded_q;

endmodule
